trig_capture_analyzer: RTL and testbench
========================================

// Module: trig_capture_analyzer
// PURPOSE
//  Parametrised multi-channel logic analyzer with pre-trigger history. Every channel is captured into a circular buffer.
//  Trigger is external, a masked pattern match on channel 0, or a combination of the two.
//  A programmable number of post-trigger samples follows the trigger.
//  Sits beside the CPU/datapath under debug; a register shim drives the control/readback ports.
// PARAMETERS
//  NUM_CH      16  number of captured channels
//  DATA_WIDTH  64  bits per channel sample
//  ADDR_WIDTH  6   buffer depth DEPTH = 2**ADDR_WIDTH
//  SEL_WIDTH   4   channel select width (2**SEL_WIDTH >= NUM_CH)
// PORTS
//  clk           in   1                    single clock
//  rst           in   1                    synchronous, active-high reset
//  din           in   NUM_CH*DATA_WIDTH    channel k = din[k*DATA_WIDTH +: DATA_WIDTH]
//  trigger       in   1                    external trigger level
//  arm           in   1                    pulse: start a new capture
//  abort         in   1                    pulse: stop capture, return to IDLE
//  trig_mode     in   2                    00 ext, 01 pattern, 10 ext|pattern, 11 ext&pattern
//  trig_mask     in   DATA_WIDTH           pattern mask, applied to channel 0
//  trig_value    in   DATA_WIDTH           pattern value; match = (ch0 & mask) == (value & mask)
//  post_count    in   ADDR_WIDTH           samples written after the trigger sample
//  rd_req        in   1                    read request
//  rd_sel        in   SEL_WIDTH            channel to read
//  rd_addr       in   ADDR_WIDTH           logical index; 0 = oldest retained sample
//  rd_valid      out  1                    1-cycle pulse; rd_data valid
//  rd_data       out  DATA_WIDTH           read data; held until the next rd_valid
//  state         out  2                    0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//  wrapped       out  1                    write pointer has wrapped during this capture
//  trig_index    out  ADDR_WIDTH           logical index of the trigger sample (valid in DONE)
//  sample_count  out  ADDR_WIDTH+1         retained samples (valid in DONE), max DEPTH
// BEHAVIOUR
//  - Reset: state=IDLE; wr_ptr, fill, wrapped, rd_valid, rd_data, trig_index, sample_count = 0. RAM contents are not reset.
//  - IDLE/DONE, arm=1: enter ARMED next cycle and clear wr_ptr, fill and wrapped. No write and no trigger evaluation on the arm cycle.
//  - ARMED:
//      - Every cycle, write all channels at wr_ptr, then wr_ptr+1 (modulo DEPTH natural wrap).
//      - The wrap from DEPTH-1 to 0 sets wrapped.
//      - fill increments, saturating at DEPTH.
//  - Trigger is evaluated in ARMED only, on the same-cycle din/trigger.
//      - The sample written that cycle is the trigger sample; trig_ptr <= wr_ptr.
//      - post_count is latched at this point.
//      - latched post_count=0 -> DONE next cycle; else TRIGGERED with remaining=post_count.
//  - TRIGGERED: writes continue; remaining decrements per write; the write with remaining==1 is the last one -> DONE.
//  - DONE: writes stop.
//      - start_ptr = wrapped ? wr_ptr : 0.
//      - sample_count = fill.
//      - trig_index = (trig_ptr - start_ptr) mod DEPTH.
//  - arm in ARMED/TRIGGERED restarts the capture as from IDLE.
//  - abort in any state: IDLE next cycle, sample_count=0. abort wins over a simultaneous arm.
//  - Read:
//      - rd_req is accepted only in IDLE or DONE; otherwise it is ignored and no rd_valid is produced.
//      - Physical address = (start_ptr + rd_addr) mod DEPTH.
//      - Fixed 2-cycle latency: rd_req at cycle N -> rd_valid at N+2 (registered RAM read + output register).
//      - Back-to-back requests are supported, one per cycle.
//      - rd_sel >= NUM_CH, or rd_addr >= sample_count, returns rd_data=0 (still with rd_valid).
//  - rst mid-capture: IDLE the next cycle, all outputs at their reset values, in-flight reads dropped.
//  - post_count up to DEPTH-1 is legal. Pre-trigger history retained = DEPTH-1-post_count samples, fewer if not wrapped.
// TESTING
//  - Wrap case: din ch0 = sample number (0 on the first ARMED write), ext trigger at sample 100, post_count=10.
//    Expect DONE after sample 110, wrapped=1, sample_count=64, rd_addr 0 -> 47, trig_index=53.
//  - No wrap: trigger at sample 5, post_count=3. Expect sample_count=9, wrapped=0, trig_index=5, rd_addr 8 -> 8, rd_addr 9 -> 0.
//  - Pattern mode: trig_mode=01, mask=0xFF, value=0x2A, trigger held high. Trigger sample is 42; mode 11 with trigger low never triggers.
//  - post_count=0, trigger at sample 20: DONE one cycle later, sample_count=21, trig_index=20, rd_addr 20 -> 20.
//  - Read handshake: rd_req in ARMED gives no rd_valid. In DONE, rd_sel=3 rd_addr=7 gives rd_valid exactly 2 cycles later; rd_sel=NUM_CH gives 0.
//  - Simultaneous arm+abort in ARMED -> IDLE. rst asserted in TRIGGERED -> IDLE, sample_count=0 next cycle.

Source files
------------

// File: rtl/trig_capture_analyzer_if.sv
`default_nettype none
// ============================================================================
// Module      : trig_capture_analyzer_if
// Description : Capture, trigger-control and readback bundle for the
//               multi-channel trigger/capture logic analyzer.
// Revision    : 1.0 - initial release
// ============================================================================
interface trig_capture_analyzer_if #(
    parameter int NUM_CH     = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int SEL_WIDTH  = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] din;
    logic                         trigger;
    logic                         arm;
    logic                         abort;
    logic [1:0]                   trig_mode;
    logic [DATA_WIDTH-1:0]        trig_mask;
    logic [DATA_WIDTH-1:0]        trig_value;
    logic [ADDR_WIDTH-1:0]        post_count;
    logic                         rd_req;
    logic [SEL_WIDTH-1:0]         rd_sel;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         rd_valid;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic [1:0]                   state;
    logic                         wrapped;
    logic [ADDR_WIDTH-1:0]        trig_index;
    logic [ADDR_WIDTH:0]          sample_count;

    modport master (
        output din, trigger, arm, abort, trig_mode, trig_mask, trig_value,
               post_count, rd_req, rd_sel, rd_addr,
        input  rd_valid, rd_data, state, wrapped, trig_index, sample_count
    );

    modport slave (
        input  din, trigger, arm, abort, trig_mode, trig_mask, trig_value,
               post_count, rd_req, rd_sel, rd_addr,
        output rd_valid, rd_data, state, wrapped, trig_index, sample_count
    );
endinterface
`default_nettype wire

// File: rtl/trig_capture_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : trig_capture_analyzer
// Description : Multi-channel logic analyzer with circular pre-trigger history,
//               ext/pattern trigger and programmable post-trigger length.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_capture_analyzer #(
    parameter int NUM_CH     = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int SEL_WIDTH  = 4
) (
    input wire                     clk,
    input wire                     rst,
    trig_capture_analyzer_if.slave bus
);
    localparam int                  c_DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FILL_MAX = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [SEL_WIDTH:0]  c_NUM_CH   = (SEL_WIDTH+1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_trig_ptr, r_remaining, r_start_ptr, r_trig_index;
    logic [ADDR_WIDTH:0]   r_fill, r_sample_count;
    logic                  r_wrapped;

    logic                  w_write, w_restart, w_fire, w_pat_hit, w_trig_hit;
    logic [DATA_WIDTH-1:0] w_ch0;

    // ------------------------------------------------------------------
    // Trigger qualification
    // ------------------------------------------------------------------
    assign w_ch0     = bus.din[DATA_WIDTH-1:0];
    assign w_pat_hit = ((w_ch0 ^ bus.trig_value) & bus.trig_mask) == '0;

    always_comb begin
        w_trig_hit = 1'b0;
        case (bus.trig_mode)
            2'b00:   w_trig_hit = bus.trigger;
            2'b01:   w_trig_hit = w_pat_hit;
            2'b10:   w_trig_hit = bus.trigger | w_pat_hit;
            default: w_trig_hit = bus.trigger & w_pat_hit;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_restart   = 1'b0;
        w_fire      = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else if (bus.arm) begin
            w_state_nxt = ST_ARMED;
            w_restart   = 1'b1;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    w_write = 1'b1;
                    if (w_trig_hit) begin
                        w_fire      = 1'b1;
                        w_state_nxt = (bus.post_count == '0) ? ST_DONE : ST_TRIGGERED;
                    end
                end
                ST_TRIGGERED: begin
                    w_write = 1'b1;
                    if (r_remaining == ADDR_WIDTH'(1)) w_state_nxt = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Post-write pointer/fill values, used to freeze the DONE summary
    logic [ADDR_WIDTH-1:0] w_wr_ptr_inc, w_trig_ptr_nxt, w_start_nxt;
    logic [ADDR_WIDTH:0]   w_fill_inc;
    logic                  w_wrapped_nxt, w_done_entry;

    assign w_wr_ptr_inc   = r_wr_ptr + 1'b1;
    assign w_wrapped_nxt  = r_wrapped | (r_wr_ptr == '1);
    assign w_fill_inc     = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_trig_ptr_nxt = w_fire ? r_wr_ptr : r_trig_ptr;
    assign w_start_nxt    = w_wrapped_nxt ? w_wr_ptr_inc : '0;
    assign w_done_entry   = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_fill         <= '0;
            r_wrapped      <= 1'b0;
            r_trig_ptr     <= '0;
            r_remaining    <= '0;
            r_start_ptr    <= '0;
            r_trig_index   <= '0;
            r_sample_count <= '0;
        end else if (w_restart) begin
            r_wr_ptr       <= '0;
            r_fill         <= '0;
            r_wrapped      <= 1'b0;
            r_start_ptr    <= '0;
            r_trig_index   <= '0;
            r_sample_count <= '0;
        end else if (bus.abort) begin
            r_sample_count <= '0;
        end else if (w_write) begin
            r_wr_ptr  <= w_wr_ptr_inc;
            r_wrapped <= w_wrapped_nxt;
            r_fill    <= w_fill_inc;
            if (w_fire) begin
                r_trig_ptr  <= r_wr_ptr;
                r_remaining <= bus.post_count;
            end else if (r_state == ST_TRIGGERED) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_done_entry) begin
                r_start_ptr    <= w_start_nxt;
                r_sample_count <= w_fill_inc;
                r_trig_index   <= w_trig_ptr_nxt - w_start_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM and two-stage readback
    // ------------------------------------------------------------------
    logic                  w_rd_accept, w_rd_in_range;
    logic [ADDR_WIDTH-1:0] w_rd_phys;
    logic [DATA_WIDTH-1:0] w_rd_q [NUM_CH];
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic                  r_rd_v1, r_rd_ok1, r_rd_valid;
    logic [SEL_WIDTH-1:0]  r_rd_sel1;
    logic [DATA_WIDTH-1:0] r_rd_data;

    assign w_rd_accept   = bus.rd_req && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_rd_phys     = r_start_ptr + bus.rd_addr;
    assign w_rd_in_range = ({1'b0, bus.rd_sel} < c_NUM_CH) &&
                           ({1'b0, bus.rd_addr} < r_sample_count);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [c_DEPTH];
        logic [DATA_WIDTH-1:0] r_q;
        // All channels read the same address; the channel is picked a stage later
        always_ff @(posedge clk) begin
            if (w_write && !rst) mem[r_wr_ptr] <= bus.din[g*DATA_WIDTH +: DATA_WIDTH];
            r_q <= mem[w_rd_phys];
        end
        assign w_rd_q[g] = r_q;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_rd_sel1 == SEL_WIDTH'(k)) w_rd_mux = w_rd_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_ok1   <= 1'b0;
            r_rd_sel1  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= w_rd_accept;
            r_rd_ok1   <= w_rd_in_range;
            r_rd_sel1  <= bus.rd_sel;
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) r_rd_data <= r_rd_ok1 ? w_rd_mux : '0;
        end
    end

    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_data      = r_rd_data;
    assign bus.state        = r_state;
    assign bus.wrapped      = r_wrapped;
    assign bus.trig_index   = r_trig_index;
    assign bus.sample_count = r_sample_count;
endmodule
`default_nettype wire

// File: tb/tb_trig_capture_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_capture_analyzer
// Description : Self-checking bench for trig_capture_analyzer with a read
//               scoreboard (expected data and arrival cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_capture_analyzer;
    localparam int NCH = 16;
    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int SW  = 5;
    localparam int DEP = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    trig_capture_analyzer_if #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

    trig_capture_analyzer #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } rd_exp_t;
    rd_exp_t sb[$];
    rd_exp_t mon_e;

    function automatic logic [DW-1:0] exp_sample(input int k, input int s);
        return (64'(k) << 48) ^ 64'(s);
    endfunction

    // Retained samples are the last min(n, DEPTH) written, oldest first
    function automatic logic [DW-1:0] exp_read(input int sel, input int addr, input int n);
        int cnt;
        cnt = (n > DEP) ? DEP : n;
        if (sel >= NCH || addr >= cnt) return '0;
        return exp_sample(sel, n - cnt + addr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int s);
        for (int k = 0; k < NCH; k++) bus.din[k*DW +: DW] = exp_sample(k, s);
    endtask

    task automatic do_read(input int sel, input int addr, input int n);
        rd_exp_t e;
        bus.rd_req  = 1'b1;
        bus.rd_sel  = SW'(sel);
        bus.rd_addr = AW'(addr);
        e.data = exp_read(sel, addr, n);
        e.at   = cyc + 2;
        sb.push_back(e);
        step();
    endtask

    task automatic drain(input string name);
        bus.rd_req = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d reads outstanding, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest request, on time
    always @(posedge clk) begin
        #1;
        if (!rst && bus.rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: rd_valid with data %h, required no rd_valid", bus.rd_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rd_data !== mon_e.data || cyc != mon_e.at) begin
                    failures++;
                    $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d",
                             bus.rd_data, cyc, mon_e.data, mon_e.at);
                end
            end
        end
    end

    task automatic capture(input logic [1:0] mode, input int ext_at, input bit ext_hold,
                           input int post, input logic [DW-1:0] mask, input logic [DW-1:0] value,
                           input int limit, input bit req_during, output int n);
        int nval;
        bus.trig_mode  = mode;
        bus.trig_mask  = mask;
        bus.trig_value = value;
        bus.post_count = AW'(post);
        bus.trigger    = 1'b0;
        bus.arm        = 1'b1;
        step();
        bus.arm    = 1'b0;
        bus.rd_req = req_during;
        nval = 0;
        n = -1;
        for (int s = 0; s < limit; s++) begin
            drive_sample(s);
            bus.trigger = ext_hold || (s == ext_at);
            step();
            if (bus.rd_valid) nval++;
            if (bus.state == 2'd3) begin
                n = s + 1;
                break;
            end
        end
        bus.rd_req  = 1'b0;
        bus.trigger = 1'b0;
        if (req_during) begin
            checks++;
            if (nval != 0) begin
                failures++;
                $display("FAIL rd_in_armed: got %0d rd_valid pulses, required 0", nval);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.state !== 2'd0 || bus.wrapped !== 1'b0 || bus.sample_count !== '0 ||
            bus.trig_index !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
            failures++;
            $display("FAIL reset: state=%0d wrapped=%0d count=%0d tidx=%0d rv=%0d rd=%h, required all 0",
                     bus.state, bus.wrapped, bus.sample_count, bus.trig_index, bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_wrap();
        int n;
        capture(2'b00, 100, 1'b0, 10, '0, '0, 200, 1'b0, n);
        checks++;
        if (n !== 111) begin failures++; $display("FAIL wrap_done: got %0d samples, required 111", n); end
        checks++;
        if (bus.wrapped !== 1'b1 || bus.sample_count !== 7'd64) begin
            failures++;
            $display("FAIL wrap_count: wrapped=%0d count=%0d, required 1 64", bus.wrapped, bus.sample_count);
        end
        checks++;
        if (bus.trig_index !== 6'd53) begin failures++; $display("FAIL wrap_tidx: got %0d, required 53", bus.trig_index); end
        do_read(0, 0, n);
        do_read(0, 53, n);
        do_read(0, 63, n);
        do_read(5, 10, n);
        do_read(15, 1, n);
        drain("wrap");
    endtask

    task automatic test_no_wrap();
        int n;
        capture(2'b00, 5, 1'b0, 3, '0, '0, 100, 1'b0, n);
        checks++;
        if (n !== 9 || bus.sample_count !== 7'd9 || bus.wrapped !== 1'b0) begin
            failures++;
            $display("FAIL nowrap_count: n=%0d count=%0d wrapped=%0d, required 9 9 0", n, bus.sample_count, bus.wrapped);
        end
        checks++;
        if (bus.trig_index !== 6'd5) begin failures++; $display("FAIL nowrap_tidx: got %0d, required 5", bus.trig_index); end
        do_read(0, 8, n);
        do_read(0, 9, n);
        do_read(2, 5, n);
        drain("nowrap");
    endtask

    task automatic test_pattern();
        int n;
        capture(2'b01, -1, 1'b1, 2, 64'hFF, 64'h2A, 100, 1'b0, n);
        checks++;
        if (n !== 45 || bus.trig_index !== 6'd42) begin
            failures++;
            $display("FAIL pattern_trig: n=%0d tidx=%0d, required 45 42", n, bus.trig_index);
        end
        do_read(0, 42, n);
        drain("pattern");
        capture(2'b11, -1, 1'b0, 2, 64'hFF, 64'h2A, 100, 1'b0, n);
        checks++;
        if (n !== -1 || bus.state !== 2'd1) begin
            failures++;
            $display("FAIL pattern_and_low: n=%0d state=%0d, required -1 1", n, bus.state);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 2'd0 || bus.sample_count !== '0) begin
            failures++;
            $display("FAIL abort: state=%0d count=%0d, required 0 0", bus.state, bus.sample_count);
        end
    endtask

    task automatic test_post_zero();
        int n;
        capture(2'b00, 20, 1'b0, 0, '0, '0, 100, 1'b0, n);
        checks++;
        if (n !== 21 || bus.sample_count !== 7'd21 || bus.trig_index !== 6'd20) begin
            failures++;
            $display("FAIL post0: n=%0d count=%0d tidx=%0d, required 21 21 20", n, bus.sample_count, bus.trig_index);
        end
        do_read(0, 20, n);
        do_read(1, 21, n);
        drain("post0");
    endtask

    task automatic test_back_to_back_reads();
        int n;
        capture(2'b00, 10, 1'b0, 4, '0, '0, 100, 1'b1, n);
        checks++;
        if (n !== 15) begin failures++; $display("FAIL handshake_done: got %0d samples, required 15", n); end
        do_read(NCH, 7, n);
        do_read(3, 7, n);
        bus.rd_req = 1'b0;
        drain("handshake");
    endtask

    task automatic test_arm_abort();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int s = 0; s < 3; s++) begin drive_sample(s); step(); end
        checks++;
        if (bus.state !== 2'd1) begin failures++; $display("FAIL armabort_pre: state=%0d, required 1", bus.state); end
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.state !== 2'd0 || bus.sample_count !== '0) begin
            failures++;
            $display("FAIL armabort: state=%0d count=%0d, required 0 0", bus.state, bus.sample_count);
        end
    endtask

    task automatic test_rst_mid();
        bus.trig_mode  = 2'b00;
        bus.post_count = 6'd20;
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int s = 0; s < 8; s++) begin
            drive_sample(s);
            bus.trigger = (s == 3);
            step();
        end
        bus.trigger = 1'b0;
        checks++;
        if (bus.state !== 2'd2) begin failures++; $display("FAIL rst_pre: state=%0d, required 2", bus.state); end
        rst = 1'b1;
        step();
        checks++;
        if (bus.state !== 2'd0 || bus.sample_count !== '0 || bus.rd_data !== '0 || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: state=%0d count=%0d rd=%h rv=%0d, required 0 0 0 0",
                     bus.state, bus.sample_count, bus.rd_data, bus.rd_valid);
        end
        rst = 1'b0;
        step();
        do_read(0, 0, 0);
        drain("idle_read");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din = '0; bus.trigger = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
        bus.trig_mode = 2'b00; bus.trig_mask = '0; bus.trig_value = '0; bus.post_count = '0;
        bus.rd_req = 1'b0; bus.rd_sel = '0; bus.rd_addr = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        test_reset();
        test_wrap();
        test_no_wrap();
        test_pattern();
        test_post_zero();
        test_back_to_back_reads();
        test_arm_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
